flow_seq_ctrl: RTL
==================

FLOW_SEQ_CTRL -- requirements
Module: flow_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result bit width, legal range 2..32.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clock.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair this cycle.
REQ-006 SHALL have port op_a  input  WIDTH  first serial-flow operand.
REQ-007 SHALL have port op_b  input  WIDTH  second serial-flow operand.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  WIDTH  serial-combined result word.
REQ-011 SHALL have port overflw  output  1  carry out of MSB position.
REQ-012 SHALL have port line1, line2  output  1 each  current serial bits driven to the comparator core (observability).
REQ-013 SHALL have port busy  output  1  high in SHIFT or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, latch op_a/op_b into shift registers, clear carry and bit counter, go SHIFT.
REQ-016 SHIFT: each cycle present LSB of each shift register on line1/line2, feed them with the carry to the core, shift result bit in MSB-first-fill so bit k lands at result[k], shift operands right, increment counter.
REQ-017 Core: sum bit = line1^line2^carry; next carry = majority(line1,line2,carry).
REQ-018 SHIFT SHALL last exactly WIDTH cycles; after the cycle processing bit WIDTH-1, go DONE, overflw = final carry.
REQ-019 Latency: acceptance at edge T -> out_valid high from edge T+WIDTH+1.
REQ-020 DONE: out_valid=1, result/overflw stable; on out_valid&out_ready go IDLE; no same-cycle acceptance of a new pair (in_ready=0 in DONE).
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and not latched.
REQ-022 line1/line2 SHALL be 0 outside SHIFT.
REQ-023 Counter SHALL be ceil(log2(WIDTH+1)) bits; it never wraps during one operation.
REQ-024 op_a/op_b changing during SHIFT SHALL NOT affect the operation in progress.

Reset
REQ-025 reset_n=0 at a rising edge SHALL force IDLE, clear shift registers, carry, counter, result, overflw.
REQ-026 Reset values: in_ready=1 (after reset edge), out_valid=0, result=0, overflw=0, line1=line2=0, busy=0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no out_valid for it.

Configuration
REQ-028 Macro FLOW_SEQ_SAT_EN: when defined, result SHALL be forced to all-ones in DONE if overflw=1; overflw still reported.
REQ-029 Without FLOW_SEQ_SAT_EN, result SHALL be the raw WIDTH-bit sum (wrapped).

Structure
REQ-030 Package flow_seq_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default-width constant.
REQ-031 Serial core (sum/carry logic of REQ-017) SHALL be a combinational sub-module flow_cmp_core; the FSM, counter and registers stay in flow_seq_ctrl.

Verification (WIDTH=8)
REQ-032 op_a=0x0F, op_b=0x01 accepted at T -> out_valid at T+9, result=0x10, overflw=0.
REQ-033 op_a=0xFF, op_b=0x01 -> overflw=1, result=0x00 without macro, 0xFF with FLOW_SEQ_SAT_EN.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid, result, overflw stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-035 reset_n=0 for one edge at SHIFT bit 3 -> next cycle IDLE, out_valid=0, busy=0; following op 0x12+0x34 -> 0x46, overflw=0.
REQ-036 in_valid held high continuously with changing operands -> only pair present at IDLE acceptance edges processed; back-to-back ops spaced WIDTH+2 cycles minimum.

Source files
------------

// File: rtl/flow_seq_pkg.sv
// flow_seq_pkg: shared definitions for the serial add/flow sequencer.
//   - state_t       : sequencer FSM states (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH : default operand/result width
//   - maj3()        : three-input majority, used as the serial carry function
package flow_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/flow_cmp_core.sv
// flow_cmp_core: combinational one-bit serial core (full adder).
// Ports:
//   bit_a, bit_b : current serial operand bits
//   carry_in     : carry from the previous bit position
//   sum          : bit_a ^ bit_b ^ carry_in
//   carry_out    : majority(bit_a, bit_b, carry_in)
module flow_cmp_core
  import flow_seq_pkg::*;
(
  input  logic bit_a,
  input  logic bit_b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = bit_a ^ bit_b ^ carry_in;
  assign carry_out = maj3(bit_a, bit_b, carry_in);

endmodule

// File: rtl/flow_seq_ctrl.sv
// flow_seq_ctrl: accepts an operand pair, adds it LSB-first over WIDTH
// cycles through flow_cmp_core, then holds the result until consumed.
// Ports:
//   clock, reset_n        : single clock, synchronous active-low reset
//   in_valid / in_ready   : operand-pair handshake (ready only in IDLE)
//   op_a, op_b            : operands, sampled at the acceptance edge only
//   out_valid / out_ready : result handshake (valid only in DONE)
//   result, overflw       : sum word and carry out of the MSB
//   line1, line2          : serial bits currently fed to the core (0 outside SHIFT)
//   busy                  : high in SHIFT or DONE
// Optional build macro FLOW_SEQ_SAT_EN: saturate result to all-ones on overflow.
// All outputs come straight from flops.
module flow_seq_ctrl
  import flow_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflw,
  output logic             line1,
  output logic             line2,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             line1_q, line1_d;
  logic             line2_q, line2_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             sum_s, carry_nxt_s;

  // The core sees the shift-register LSBs; line1/line2 flops mirror them in SHIFT.
  flow_cmp_core u_core (
    .bit_a     (a_sh_q[0]),
    .bit_b     (b_sh_q[0]),
    .carry_in  (carry_q),
    .sum       (sum_s),
    .carry_out (carry_nxt_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          res_d   = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so bit k ends at result[k] after WIDTH shifts.
        res_d   = {sum_s, res_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = carry_nxt_s;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          ovf_d   = carry_nxt_s;
`ifdef FLOW_SEQ_SAT_EN
          if (carry_nxt_s) begin
            res_d = {WIDTH{1'b1}};
          end else begin
            res_d = {sum_s, res_q[WIDTH-1:1]};
          end
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == SHIFT) || (state_d == DONE);
    line1_d     = (state_d == SHIFT) ? a_sh_d[0] : 1'b0;
    line2_d     = (state_d == SHIFT) ? b_sh_d[0] : 1'b0;
    // Valid rises one cycle after DONE is entered and drops on the handshake edge.
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_sh_q      <= {WIDTH{1'b0}};
      b_sh_q      <= {WIDTH{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      line1_q     <= 1'b0;
      line2_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign overflw   = ovf_q;
  assign line1     = line1_q;
  assign line2     = line2_q;
  assign busy      = busy_q;

endmodule
